// File: rtl/jt10_snd_pkg.sv
// Shared definitions for the jt10 sound output path: FSM encoding, default
// word width / bit-clock divider, and the slot-counter width helper.
package jt10_snd_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_BCK_DIV = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } snd_state_t;

    // Bits needed to count the 2*width slots of one stereo frame
    function automatic int slot_cnt_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/jt10_snd_clkdiv.sv
// Bit-clock generator: divides clk by 2*BCK_DIV to form bck and flags the
// clk edge on which bck will rise or fall. Held at bck=0 while hold=1.
module jt10_snd_clkdiv
    import jt10_snd_pkg::*;
#(
    parameter int BCK_DIV = DEF_BCK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic bck,
    output logic bck_fall,
    output logic bck_rise
);

    localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic             bck_reg;
    logic             wrap;

    assign wrap     = (div_reg == DIV_LAST);
    // Strobes mark the clk edge at which bck changes, so the consumer can
    // update its registers on that very edge.
    assign bck_rise = !hold && wrap && !bck_reg;
    assign bck_fall = !hold && wrap &&  bck_reg;
    assign bck      = bck_reg;

    // Divider counter and bck toggle; cleared while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
            bck_reg <= 1'b0;
        end else if (hold) begin
            div_reg <= '0;
            bck_reg <= 1'b0;
        end else if (wrap) begin
            div_reg <= '0;
            bck_reg <= ~bck_reg;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

endmodule

// File: rtl/jt10_snd_serial.sv
// Stereo sample serialiser for the YM2610 output stage. Double-buffers the
// left/right mix and streams it MSB first to a DAC.
// Build option: define JT10_SND_SERIAL_LJ_EN for left-justified framing;
// otherwise standard I2S (data delayed one slot behind lrck).
module jt10_snd_serial
    import jt10_snd_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BCK_DIV = DEF_BCK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sample_stb,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             clr_flags,
    output logic             bck,
    output logic             lrck,
    output logic             sdata,
    output logic             busy,
    output logic             underrun,
    output logic             overrun
);

    localparam int FW = 2 * WIDTH;
    localparam int SW = slot_cnt_w(WIDTH);
    localparam logic [SW-1:0] SLOT_LAST = SW'(FW - 1);
    localparam logic [SW-1:0] SLOT_HALF = SW'(WIDTH);

    snd_state_t     state_reg, state_next;
    logic [SW-1:0]  slot_reg;
    logic [FW-1:0]  pend_reg;
    logic           pend_valid_reg;
    logic [FW-1:0]  word_reg;
    logic [FW-1:0]  shift_reg;
    logic           lrck_reg;
    logic           sdata_reg;
    logic           underrun_reg;
    logic           overrun_reg;

    logic           run;
    logic           bck_fall;
    logic           bck_rise;
    logic           unused_rise;
    logic           start_idle;
    logic           frame_end;
    logic           stop;
    logic           frame_start;
    logic           slot_adv;
    logic           stb_bypass;
    logic [FW-1:0]  load_word;
    logic [SW-1:0]  slot_inc;

    jt10_snd_clkdiv #(
        .BCK_DIV (BCK_DIV)
    ) u_clkdiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (!run),
        .bck      (bck),
        .bck_fall (bck_fall),
        .bck_rise (bck_rise)
    );

    // The DAC samples on the rise; the frame logic only acts on the fall.
    assign unused_rise = bck_rise;

    assign run      = (state_reg == ST_RUN);
    assign slot_inc = slot_reg + 1'b1;

    // Frame sequencing events. Starting from IDLE with only a strobe (pending
    // still empty) ships the incoming sample directly so busy and slot 0
    // follow the strobe by one clk.
    always_comb begin
        start_idle  = 1'b0;
        frame_end   = 1'b0;
        stop        = 1'b0;
        frame_start = 1'b0;
        slot_adv    = 1'b0;
        stb_bypass  = 1'b0;
        load_word   = word_reg;

        start_idle  = !run && en && (pend_valid_reg || sample_stb);
        frame_end   = run && bck_fall && (slot_reg == SLOT_LAST);
        stop        = frame_end && !en;
        frame_start = start_idle || (frame_end && en);
        slot_adv    = run && bck_fall && !frame_end;
        stb_bypass  = start_idle && !pend_valid_reg;

        if (pend_valid_reg) begin
            load_word = pend_reg;
        end else if (stb_bypass) begin
            load_word = {left, right};
        end
    end

    // Next-state logic: leave IDLE on a sample, leave RUN only at frame end
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_idle) state_next = ST_RUN;
            ST_RUN:  if (stop)       state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pending buffer: strobe always wins over the frame-start consume, so a
    // coincident sample survives into the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
        end else if (sample_stb && !stb_bypass) begin
            pend_reg       <= {left, right};
            pend_valid_reg <= 1'b1;
        end else if (frame_start) begin
            pend_valid_reg <= 1'b0;
        end
    end

    // Slot counter, word select and shift-out; everything moves on the bck
    // fall (or RUN entry) so the DAC sees stable data at the rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg  <= '0;
            word_reg  <= '0;
            shift_reg <= '0;
            lrck_reg  <= 1'b0;
            sdata_reg <= 1'b0;
        end else if (frame_start) begin
            slot_reg  <= '0;
            word_reg  <= load_word;
            lrck_reg  <= 1'b0;
`ifdef JT10_SND_SERIAL_LJ_EN
            shift_reg <= {load_word[FW-2:0], 1'b0};
            sdata_reg <= load_word[FW-1];
`else
            // After 2W-1 shifts the previous right LSB sits at the top
            shift_reg <= load_word;
            sdata_reg <= start_idle ? 1'b0 : shift_reg[FW-1];
`endif
        end else if (stop) begin
            slot_reg  <= '0;
            lrck_reg  <= 1'b0;
            sdata_reg <= 1'b0;
        end else if (slot_adv) begin
            slot_reg  <= slot_inc;
            lrck_reg  <= (slot_inc >= SLOT_HALF);
            sdata_reg <= shift_reg[FW-1];
            shift_reg <= {shift_reg[FW-2:0], 1'b0};
        end
    end

    // Sticky status flags; a set in the same clk as clr_flags takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            if (frame_start && !pend_valid_reg && !start_idle) begin
                underrun_reg <= 1'b1;
            end else if (clr_flags) begin
                underrun_reg <= 1'b0;
            end
            if (sample_stb && pend_valid_reg && !frame_start) begin
                overrun_reg <= 1'b1;
            end else if (clr_flags) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign lrck     = lrck_reg;
    assign sdata    = sdata_reg;
    assign busy     = run;
    assign underrun = underrun_reg;
    assign overrun  = overrun_reg;

endmodule
